// File: rtl/program_loader.sv
// rtl/program_loader.sv - framed byte-stream boot loader for the CPU instruction memory
module program_loader #(
  parameter int INSTR_MEM_SIZE = 64,
  parameter int ADDR_WIDTH     = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            in_byte,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error
);

  localparam logic [2:0] S_COUNT = 3'd0;
  localparam logic [2:0] S_DATA  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERROR = 3'd5;

  localparam logic [7:0] MAX_N = 8'(INSTR_MEM_SIZE);

  logic [2:0]  state;
  // Low only in the first cycle out of reset so in_ready stays low while reset is held
  logic        active;
  logic [7:0]  n;
  // Kept 8 bits wide so it compares directly against the count byte
  logic [7:0]  widx;
  logic [1:0]  bidx;
  // Only the first three bytes are stored; the fourth goes straight into imem_wdata
  logic [23:0] word;
  logic [7:0]  acc;
  logic        xfer;

  // Ready is a pure state decode so nothing depends combinationally on in_valid
  assign in_ready = active && ((state == S_COUNT) || (state == S_DATA) || (state == S_CHECK));
  assign xfer     = in_valid && in_ready;

  // Frame parser, word assembler, checksum accumulator and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_COUNT;
      active     <= 1'b0;
      n          <= 8'd0;
      widx       <= 8'd0;
      bidx       <= 2'd0;
      word       <= 24'd0;
      acc        <= 8'd0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      cpu_reset  <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      active  <= 1'b1;
      imem_we <= 1'b0;
      case (state)
        S_COUNT: begin
          if (xfer) begin
            n    <= in_byte;
            widx <= 8'd0;
            bidx <= 2'd0;
            acc  <= 8'd0;
            if ((in_byte == 8'd0) || (in_byte > MAX_N)) begin
              state <= S_ERROR;
              error <= 1'b1;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
            acc  <= acc ^ in_byte;
            bidx <= bidx + 2'd1;
            word <= {word[15:0], in_byte};
            if (bidx == 2'd3) begin
              state      <= S_WRITE;
              imem_we    <= 1'b1;
              imem_addr  <= widx[ADDR_WIDTH-1:0];
              imem_wdata <= {word, in_byte};
            end
          end
        end
        S_WRITE: begin
          widx  <= widx + 8'd1;
          state <= (widx == n - 8'd1) ? S_CHECK : S_DATA;
        end
        S_CHECK: begin
          if (xfer) begin
            if (in_byte == acc) begin
              state     <= S_DONE;
              done      <= 1'b1;
              cpu_reset <= 1'b1;
            end else begin
              state <= S_ERROR;
              error <= 1'b1;
            end
          end
        end
        S_DONE:  state <= S_DONE;
        S_ERROR: state <= S_ERROR;
        default: state <= S_ERROR;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed self-checking bench for program_loader
module tb_program_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  in_byte = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        imem_we;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        error;

  int n_checks = 0;
  int n_fail   = 0;

  logic [5:0]  wa[$];
  logic [31:0] wd[$];

  program_loader #(.INSTR_MEM_SIZE(64), .ADDR_WIDTH(6)) dut (
    .clock(clock), .reset(reset), .in_byte(in_byte), .in_valid(in_valid),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  // Record every write pulse away from the rising edge
  always @(negedge clock) begin
    if (reset && imem_we) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stall);
    int t;
    if (stall) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        tick();
      end
    end
    in_byte  = b;
    in_valid = 1'b1;
    t = 0;
    while (in_ready !== 1'b1 && t < 20) begin
      tick();
      t++;
    end
    if (in_ready !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL handshake_timeout: in_ready=%b required 1 for byte %02h", in_ready, b);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    wa.delete();
    wd.delete();
  endtask

  task automatic check_two_word_writes(input string tag);
    n_checks++;
    if (wa.size() !== 2) begin
      n_fail++; $display("FAIL %s_write_count: got %0d required 2", tag, wa.size());
    end else begin
      n_checks++;
      if (wa[0] !== 6'd0 || wd[0] !== 32'h20080005) begin
        n_fail++; $display("FAIL %s_write0: got %0d/%08h required 0/20080005", tag, wa[0], wd[0]);
      end
      n_checks++;
      if (wa[1] !== 6'd1 || wd[1] !== 32'h8C090010) begin
        n_fail++; $display("FAIL %s_write1: got %0d/%08h required 1/8c090010", tag, wa[1], wd[1]);
      end
    end
  endtask

  task automatic test_reset();
    in_valid = 1'b0;
    reset = 1'b0;
    repeat (2) tick();
    n_checks++;
    if ({in_ready, imem_we, imem_addr, imem_wdata, cpu_reset, done, error} !== 43'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy=%b we=%b addr=%0d wdata=%08h cpu=%b done=%b err=%b required all 0",
               in_ready, imem_we, imem_addr, imem_wdata, cpu_reset, done, error);
    end
    reset = 1'b1;
    tick();
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL ready_after_release: got %b required 1", in_ready);
    end
    wa.delete();
    wd.delete();
  endtask

  task automatic test_two_word();
    logic [7:0] s [9];
    s = '{8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h10};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      send_byte(s[i], 1'b0);
      if (i == 4) begin
        n_checks++;
        if (imem_we !== 1'b1 || imem_addr !== 6'd0 || imem_wdata !== 32'h20080005 || in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL write_latency: we=%b addr=%0d wdata=%08h rdy=%b required 1/0/20080005/0",
                   imem_we, imem_addr, imem_wdata, in_ready);
        end
      end
    end
    n_checks++;
    if (cpu_reset !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL cpu_held_before_check: cpu_reset=%b done=%b required 0/0", cpu_reset, done);
    end
    send_byte(8'hB8, 1'b0);
    n_checks++;
    if (done !== 1'b1 || cpu_reset !== 1'b1 || error !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL two_word_done: done=%b cpu=%b err=%b rdy=%b required 1/1/0/0", done, cpu_reset, error, in_ready);
    end
    repeat (3) tick();
    check_two_word_writes("two_word");
  endtask

  task automatic test_illegal_count();
    logic [7:0] bad [2];
    bad = '{8'h00, 8'h41};
    for (int k = 0; k < 2; k++) begin
      do_reset();
      send_byte(bad[k], 1'b0);
      n_checks++;
      if (error !== 1'b1 || done !== 1'b0 || cpu_reset !== 1'b0 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL illegal_count_%02h: err=%b done=%b cpu=%b rdy=%b required 1/0/0/0",
                 bad[k], error, done, cpu_reset, in_ready);
      end
      repeat (3) tick();
      n_checks++;
      if (wa.size() !== 0 || error !== 1'b1) begin
        n_fail++; $display("FAIL illegal_count_nowrite_%02h: writes=%0d err=%b required 0/1", bad[k], wa.size(), error);
      end
    end
  endtask

  task automatic test_bad_checksum();
    logic [7:0] s [10];
    s = '{8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h10, 8'hB9};
    do_reset();
    for (int i = 0; i < 10; i++) send_byte(s[i], 1'b0);
    n_checks++;
    if (error !== 1'b1 || done !== 1'b0 || cpu_reset !== 1'b0) begin
      n_fail++; $display("FAIL bad_checksum: err=%b done=%b cpu=%b required 1/0/0", error, done, cpu_reset);
    end
    repeat (2) tick();
    check_two_word_writes("bad_checksum");
  endtask

  task automatic test_full_memory();
    int bad_cnt;
    do_reset();
    send_byte(8'h40, 1'b1);
    for (int i = 0; i < 64; i++) begin
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'(i), 1'b1);
    end
    send_byte(8'h00, 1'b1);
    n_checks++;
    if (done !== 1'b1 || error !== 1'b0 || cpu_reset !== 1'b1) begin
      n_fail++; $display("FAIL full_done: done=%b err=%b cpu=%b required 1/0/1", done, error, cpu_reset);
    end
    repeat (2) tick();
    n_checks++;
    if (wa.size() !== 64) begin
      n_fail++; $display("FAIL full_write_count: got %0d required 64", wa.size());
    end else begin
      bad_cnt = 0;
      for (int i = 0; i < 64; i++) begin
        if (wa[i] !== 6'(i) || wd[i] !== 32'(i)) bad_cnt++;
      end
      n_checks++;
      if (bad_cnt != 0) begin
        n_fail++; $display("FAIL full_write_order: %0d entries wrong, required 0 (last addr %0d)", bad_cnt, wa[63]);
      end
    end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] s [7];
    s = '{8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09};
    do_reset();
    for (int i = 0; i < 7; i++) send_byte(s[i], 1'b0);
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, imem_we, imem_addr, imem_wdata, cpu_reset, done, error} !== 43'd0) begin
      n_fail++;
      $display("FAIL mid_word_async_reset: rdy=%b we=%b addr=%0d wdata=%08h cpu=%b done=%b err=%b required all 0",
               in_ready, imem_we, imem_addr, imem_wdata, cpu_reset, done, error);
    end
    tick();
    reset = 1'b1;
    tick();
    wa.delete();
    wd.delete();
    s = '{8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09};
    for (int i = 0; i < 7; i++) send_byte(s[i], 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h10, 1'b0);
    send_byte(8'hB8, 1'b0);
    n_checks++;
    if (done !== 1'b1 || error !== 1'b0) begin
      n_fail++; $display("FAIL mid_word_reload_done: done=%b err=%b required 1/0", done, error);
    end
    repeat (2) tick();
    check_two_word_writes("mid_word_reload");
  endtask

  task automatic test_handshake_stall();
    int stall_bad;
    do_reset();
    send_byte(8'h02, 1'b0);
    send_byte(8'h20, 1'b0);
    send_byte(8'h08, 1'b0);
    in_byte = 8'hFF;
    stall_bad = 0;
    for (int c = 0; c < 10; c++) begin
      if (in_ready !== 1'b1 || imem_we !== 1'b0 || done !== 1'b0 || error !== 1'b0) stall_bad++;
      tick();
    end
    n_checks++;
    if (stall_bad != 0) begin
      n_fail++; $display("FAIL stall_hold: %0d stalled cycles changed state, required 0", stall_bad);
    end
    send_byte(8'h00, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h8C, 1'b0);
    send_byte(8'h09, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h10, 1'b0);
    send_byte(8'hB8, 1'b0);
    n_checks++;
    if (done !== 1'b1 || error !== 1'b0) begin
      n_fail++; $display("FAIL stall_done: done=%b err=%b required 1/0", done, error);
    end
    repeat (2) tick();
    check_two_word_writes("stall");
  endtask

  initial begin
    test_reset();
    test_two_word();
    test_illegal_count();
    test_bad_checksum();
    test_full_memory();
    test_reset_mid_word();
    test_handshake_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
